// File: rtl/rtc_pkg.sv
// Shared definitions for the cascaded real-time counter.
//   MAX_STAGES    : largest supported number of cascaded stages
//   DEFAULT_WIDTH : default bit width of each stage count
//   dir_e         : counting direction as seen on the 'down' input
package rtc_pkg;

    localparam int MAX_STAGES    = 8;
    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/rtc_stage.sv
// One counter stage of the cascade.
//   clk, reset  : clock and synchronous active-high reset
//   carry_in    : advance this stage this cycle
//   down        : 0 = count up, 1 = count down
//   max         : terminal value of this stage
//   load        : synchronous preset strobe (wins over carry_in)
//   load_value  : preset value, clamped to max
//   count       : registered stage count
//   terminal    : stage sits at its terminal value for the current direction
//   wrap_next   : stage takes its terminal transition at the coming edge
//   count_next  : value the stage will hold after the coming edge
module rtc_stage
    import rtc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carry_in,
    input  logic             down,
    input  logic [WIDTH-1:0] max,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             wrap_next,
    output logic [WIDTH-1:0] count_next
);

    dir_e             dir;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] load_sat;

    assign dir = dir_e'(down);

    always_comb begin
        // ">=" rather than "==" so a stage left above a freshly lowered max
        // still wraps to 0 on its next carry instead of running away.
        if (dir == DIR_DOWN) begin
            terminal = (count_reg == '0);
        end else begin
            terminal = (count_reg >= max);
        end

        load_sat = (load_value > max) ? max : load_value;

        count_next = count_reg;
        if (load) begin
            count_next = load_sat;
        end else if (carry_in) begin
            if (terminal) begin
                count_next = (dir == DIR_DOWN) ? max : '0;
            end else if (dir == DIR_DOWN) begin
                count_next = count_reg - WIDTH'(1);
            end else begin
                count_next = count_reg + WIDTH'(1);
            end
        end
    end

    // A preset is never reported as a wrap.
    assign wrap_next = carry_in & terminal & ~load;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/rtc_cascade.sv
// Cascaded multi-stage counter with preset, per-stage wrap pulses,
// full-rollover pulse and a one-shot alarm comparator.
//   clk, reset   : clock and synchronous active-high reset
//   en           : count enable feeding stage 0
//   down         : 0 = count up, 1 = count down
//   count_max    : per-stage terminal values (index 0 least significant)
//   load         : synchronous preset strobe, priority over counting
//   load_value   : per-stage preset values (clamped to count_max)
//   alarm_en     : arms the alarm comparator
//   alarm_value  : per-stage alarm match value
//   count        : registered per-stage counts
//   wrap         : registered one-cycle pulse per stage on wrap
//   rollover     : registered one-cycle pulse when every stage wraps together
//   alarm        : registered one-cycle pulse on entering alarm_value
module rtc_cascade
    import rtc_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int WIDTH      = DEFAULT_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             down,
    input  logic [NUM_STAGES-1:0][WIDTH-1:0] count_max,
    input  logic                             load,
    input  logic [NUM_STAGES-1:0][WIDTH-1:0] load_value,
    input  logic                             alarm_en,
    input  logic [NUM_STAGES-1:0][WIDTH-1:0] alarm_value,
    output logic [NUM_STAGES-1:0][WIDTH-1:0] count,
    output logic [NUM_STAGES-1:0]            wrap,
    output logic                             rollover,
    output logic                             alarm
);

    // carry[i] advances stage i; carry[NUM_STAGES] means every stage wrapped.
    logic [NUM_STAGES:0]                carry;
    logic [NUM_STAGES-1:0]              terminal;
    logic [NUM_STAGES-1:0]              wrap_next;
    logic [NUM_STAGES-1:0][WIDTH-1:0]   count_next;

    logic [NUM_STAGES-1:0]              wrap_reg;
    logic                               rollover_reg;
    logic                               alarm_reg;
    logic                               rollover_next;
    logic                               alarm_next;

    assign carry[0] = en;

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            rtc_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .carry_in   (carry[gi]),
                .down       (down),
                .max        (count_max[gi]),
                .load       (load),
                .load_value (load_value[gi]),
                .count      (count[gi]),
                .terminal   (terminal[gi]),
                .wrap_next  (wrap_next[gi]),
                .count_next (count_next[gi])
            );

            assign carry[gi+1] = carry[gi] & terminal[gi];
        end
    endgenerate

    assign rollover_next = carry[NUM_STAGES] & ~load;

    // Requiring a change in count keeps the alarm one-shot while the
    // counter idles on the alarm value.
    assign alarm_next = alarm_en
                      && (count_next == alarm_value)
                      && (count_next != count);

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_reg     <= '0;
            rollover_reg <= 1'b0;
            alarm_reg    <= 1'b0;
        end else begin
            wrap_reg     <= wrap_next;
            rollover_reg <= rollover_next;
            alarm_reg    <= alarm_next;
        end
    end

    assign wrap     = wrap_reg;
    assign rollover = rollover_reg;
    assign alarm    = alarm_reg;

endmodule

// File: tb/tb_rtc_cascade.sv
// Self-checking bench for rtc_cascade (3 stages, 32-bit counts).
// A behavioural model advances the expected state on every rising edge;
// a compare process checks DUT against it on every falling edge. Directed
// scenarios also pin the outputs to hand-computed literals.
module tb_rtc_cascade;

    localparam int N = 3;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 en;
    logic                 down;
    logic                 load;
    logic                 alarm_en;
    logic [N-1:0][W-1:0]  count_max;
    logic [N-1:0][W-1:0]  load_value;
    logic [N-1:0][W-1:0]  alarm_value;
    logic [N-1:0][W-1:0]  count;
    logic [N-1:0]         wrap;
    logic                 rollover;
    logic                 alarm;

    rtc_cascade #(
        .NUM_STAGES (N),
        .WIDTH      (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .down        (down),
        .count_max   (count_max),
        .load        (load),
        .load_value  (load_value),
        .alarm_en    (alarm_en),
        .alarm_value (alarm_value),
        .count       (count),
        .wrap        (wrap),
        .rollover    (rollover),
        .alarm       (alarm)
    );

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the cascade as a ripple of "advance" requests.
    // ------------------------------------------------------------------
    logic [N-1:0][W-1:0] m_count;
    logic [N-1:0]        m_wrap;
    logic                m_roll;
    logic                m_alarm;
    logic                m_valid = 1'b0;

    logic [N-1:0][W-1:0] t_count;
    logic [N-1:0]        t_wrap;
    logic                t_roll;
    logic                t_alarm;

    task automatic model_step(output logic [N-1:0][W-1:0] nc, output logic [N-1:0] nw,
                              output logic nr, output logic na);
        logic ripple;
        logic at_end;
        nc = m_count;
        nw = '0;
        nr = 1'b0;
        na = 1'b0;
        if (reset) begin
            nc = '0;
        end else begin
            if (load) begin
                for (int i = 0; i < N; i++)
                    nc[i] = (load_value[i] < count_max[i]) ? load_value[i] : count_max[i];
            end else begin
                ripple = en;
                for (int i = 0; i < N; i++) begin
                    if (ripple) begin
                        at_end = down ? (m_count[i] == 32'd0) : (m_count[i] >= count_max[i]);
                        if (at_end) begin
                            nc[i] = down ? count_max[i] : 32'd0;
                            nw[i] = 1'b1;
                        end else begin
                            nc[i] = down ? m_count[i] - 32'd1 : m_count[i] + 32'd1;
                            ripple = 1'b0;
                        end
                    end
                end
                nr = ripple;
            end
            na = alarm_en && (nc == alarm_value) && (nc != m_count);
        end
    endtask

    always @(posedge clk) begin
        model_step(t_count, t_wrap, t_roll, t_alarm);
        m_count <= t_count;
        m_wrap  <= t_wrap;
        m_roll  <= t_roll;
        m_alarm <= t_alarm;
        m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count",    128'(count),    128'(m_count));
            check("model_wrap",     128'(wrap),     128'(m_wrap));
            check("model_rollover", 128'(rollover), 128'(m_roll));
            check("model_alarm",    128'(alarm),    128'(m_alarm));
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_lit(input string tag, input logic [W-1:0] c0, input logic [W-1:0] c1,
                              input logic [W-1:0] c2, input logic [2:0] w, input logic r,
                              input logic a);
        logic [N-1:0][W-1:0] exp_c;
        exp_c[0] = c0;
        exp_c[1] = c1;
        exp_c[2] = c2;
        check({tag, "_count"},    128'(count),    128'(exp_c));
        check({tag, "_wrap"},     128'(wrap),     128'(w));
        check({tag, "_rollover"}, 128'(rollover), 128'(r));
        check({tag, "_alarm"},    128'(alarm),    128'(a));
    endtask

    task automatic set_lv(input logic [W-1:0] v0, input logic [W-1:0] v1, input logic [W-1:0] v2);
        load_value[0] = v0;
        load_value[1] = v1;
        load_value[2] = v2;
    endtask

    task automatic default_max();
        count_max[0] = 32'd59;
        count_max[1] = 32'd59;
        count_max[2] = 32'd23;
    endtask

    initial begin
        reset       = 1'b1;
        en          = 1'b0;
        down        = 1'b0;
        load        = 1'b0;
        alarm_en    = 1'b0;
        load_value  = '0;
        alarm_value = '0;
        default_max();
        step();
        step();
        expect_lit("reset", 0, 0, 0, 3'b000, 1'b0, 1'b0);
        reset = 1'b0;

        // Up-count wrap through all stages
        set_lv(58, 59, 23); load = 1'b1; step(); load = 1'b0;
        en = 1'b1; step();
        expect_lit("up_pre", 59, 59, 23, 3'b000, 1'b0, 1'b0);
        step();
        expect_lit("up_wrap", 0, 0, 0, 3'b111, 1'b1, 1'b0);
        en = 1'b0; step();
        expect_lit("up_after", 0, 0, 0, 3'b000, 1'b0, 1'b0);

        // Down-count wrap
        set_lv(0, 0, 0); load = 1'b1; step(); load = 1'b0;
        down = 1'b1; en = 1'b1; step();
        expect_lit("down_wrap", 59, 59, 23, 3'b111, 1'b1, 1'b0);
        en = 1'b0; down = 1'b0; step();

        // Load priority and clamping
        set_lv(10, 20, 5); load = 1'b1; en = 1'b1; step();
        expect_lit("load_prio", 10, 20, 5, 3'b000, 1'b0, 1'b0);
        set_lv(99, 0, 0); step();
        expect_lit("load_clamp", 59, 0, 0, 3'b000, 1'b0, 1'b0);
        load = 1'b0; en = 1'b0;

        // Alarm one-shot
        set_lv(0, 0, 0); load = 1'b1; step(); load = 1'b0;
        alarm_value[0] = 2; alarm_value[1] = 0; alarm_value[2] = 0;
        alarm_en = 1'b1; en = 1'b1; step();
        expect_lit("alarm_1", 1, 0, 0, 3'b000, 1'b0, 1'b0);
        step();
        expect_lit("alarm_hit", 2, 0, 0, 3'b000, 1'b0, 1'b1);
        en = 1'b0; step();
        expect_lit("alarm_hold", 2, 0, 0, 3'b000, 1'b0, 1'b0);
        step();
        expect_lit("alarm_hold2", 2, 0, 0, 3'b000, 1'b0, 1'b0);
        alarm_en = 1'b0;

        // Reset in the cycle that would roll over
        set_lv(59, 59, 23); load = 1'b1; step(); load = 1'b0;
        en = 1'b1; reset = 1'b1; step();
        expect_lit("rst_mid", 0, 0, 0, 3'b000, 1'b0, 1'b0);
        reset = 1'b0; en = 1'b0; step();
        expect_lit("rst_idle", 0, 0, 0, 3'b000, 1'b0, 1'b0);
        en = 1'b1; step();
        expect_lit("rst_first", 1, 0, 0, 3'b000, 1'b0, 1'b0);
        en = 1'b0;

        // Zero max on stage 0
        set_lv(0, 0, 0); load = 1'b1; step(); load = 1'b0;
        count_max[0] = 0; en = 1'b1; step();
        expect_lit("zmax_1", 0, 1, 0, 3'b001, 1'b0, 1'b0);
        step();
        expect_lit("zmax_2", 0, 2, 0, 3'b001, 1'b0, 1'b0);
        en = 1'b0; default_max();
        step();

        // Randomized phase against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 9) == 0);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) down = ~down;
            if ($urandom_range(0, 39) == 0) begin
                for (int i = 0; i < N; i++) count_max[i] = 32'($urandom_range(0, 6));
            end else if ($urandom_range(0, 39) == 0) begin
                default_max();
            end
            for (int i = 0; i < N; i++) load_value[i] = 32'($urandom_range(0, 70));
            alarm_en = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) begin
                alarm_value    = m_count;
                alarm_value[0] = down ? m_count[0] - 32'd1 : m_count[0] + 32'd1;
            end
            step();
        end

        reset = 1'b0; en = 1'b0; load = 1'b0;
        step();
        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rtc_cascade.md
RTC_CASCADE -- requirements
Module: rtc_cascade

Interface
REQ-001 Parameter NUM_STAGES, default 3, number of cascaded counter stages; legal range 1..8.
REQ-002 Parameter WIDTH, default 32, bit width of every stage count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 en  input  1  count enable for stage 0.
REQ-006 down  input  1  0 = count up, 1 = count down.
REQ-007 count_max  input  [NUM_STAGES][WIDTH]  terminal (maximum) value per stage.
REQ-008 load  input  1  synchronous preset strobe.
REQ-009 load_value  input  [NUM_STAGES][WIDTH]  preset values.
REQ-010 alarm_en  input  1  arms the alarm comparator.
REQ-011 alarm_value  input  [NUM_STAGES][WIDTH]  alarm match value.
REQ-012 count  output  [NUM_STAGES][WIDTH]  registered per-stage counts; index 0 is least significant.
REQ-013 wrap  output  [NUM_STAGES]  registered one-cycle pulse per stage on wrap.
REQ-014 rollover  output  1  registered one-cycle pulse when all stages wrap in the same cycle.
REQ-015 alarm  output  1  registered one-cycle alarm pulse.

Function
REQ-016 Stage i terminal: up mode when count[i] >= count_max[i]; down mode when count[i] == 0.
REQ-017 carry[0] = en; carry[i+1] = carry[i] AND stage i terminal; combinational within one cycle.
REQ-018 Up mode, carry[i]=1: non-terminal stage increments by 1; terminal stage loads 0.
REQ-019 Down mode, carry[i]=1: non-terminal stage decrements by 1; terminal stage loads count_max[i].
REQ-020 Stage with carry[i]=0 holds its value.
REQ-021 wrap[i] asserts the cycle after stage i took its terminal transition under REQ-018/019.
REQ-022 rollover asserts the cycle after carry[NUM_STAGES-1] AND stage NUM_STAGES-1 terminal.
REQ-023 load has priority over counting; per stage, count <= min(load_value[i], count_max[i]).
REQ-024 A load cycle produces no wrap and no rollover pulse.
REQ-025 count_max[i]==0: stage stays 0, is always terminal, and passes carry every enabled cycle.
REQ-026 Reducing count_max below a stage's current count: up mode wraps that stage to 0 on its next carry; down mode decrements normally.
REQ-027 Toggling down takes effect in the same cycle it is sampled; no state is lost.
REQ-028 alarm asserts the cycle after the update when alarm_en=1, next count equals alarm_value on all stages, and next count differs from current count.
REQ-029 Holding at the alarm value (en=0) fires alarm at most once.
REQ-030 Latency from input sample to count, wrap, rollover and alarm is exactly 1 cycle.

Reset
REQ-031 reset=1 sets all count stages to 0 and clears wrap, rollover and alarm to 0.
REQ-032 Reset has priority over load and en.
REQ-033 Reset mid-count discards any pending pulse; the first update occurs in the first cycle after reset deasserts.

Structure
REQ-034 Shared package rtc_pkg holds MAX_STAGES=8 and the default WIDTH constant.
REQ-035 rtc_pkg holds an enum dir_e {DIR_UP, DIR_DOWN}.
REQ-036 One sub-module, rtc_stage: a single counter stage with inputs carry_in, down, max, load and load_value, and outputs count, terminal and wrap_next.
REQ-037 rtc_cascade instantiates rtc_stage in a generate loop and builds the carry chain.
REQ-038 rtc_cascade also holds the rollover and alarm registers.

Verification
REQ-039 All scenarios use NUM_STAGES=3 and count_max={59,59,23}.
REQ-040 Up-count wrap: load {58,59,23}, en=1 for 2 cycles -> count {59,59,23} then {0,0,0}; wrap=3'b111 and rollover=1 for exactly one cycle.
REQ-041 Down-count wrap: load {0,0,0}, down=1, en=1 for 1 cycle -> count {59,59,23}; wrap=3'b111 and rollover=1.
REQ-042 Load priority: load={10,20,5} with en=1 in the same cycle -> count {10,20,5}, no wrap; load {99,0,0} -> count {59,0,0}.
REQ-043 Alarm: alarm_value={2,0,0}, alarm_en=1, en pulses from {0,0,0} -> alarm pulses once when count reaches {2,0,0}; holding with en=0 keeps alarm=0.
REQ-044 Reset mid-wrap: assert reset in the cycle that would cause rollover -> count {0,0,0}; wrap, rollover and alarm stay 0.
REQ-045 Zero max: count_max[0]=0, en=1 -> stage 0 stays 0 and stage 1 increments every cycle.
